// File: rtl/fetch_mem_unit.sv
// Fetch/memory stage: holds PC, MAR, MBR and IR, and runs byte
// transactions to RAM over a req/ack handshake with wait states and a
// timeout. busy holds the control unit while a transaction is open.
module fetch_mem_unit #(
    parameter int          TIMEOUT  = 16,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic       fu_clk,
    input  logic       fu_rst_n,
    input  logic       PC_inc,
    input  logic       MAR_we,
    input  logic       MAR_mux,
    input  logic       MBR_we,
    input  logic       MBR_mux,
    input  logic       IR_we,
    input  logic       RAM_we,
    input  logic [7:0] rf_data,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic [7:0] ir_out,
    output logic [7:0] mbr_out,
    output logic [7:0] pc_out,
    output logic       busy,
    output logic       mem_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] pc;
    logic [7:0] mar;
    logic [7:0] mbr;
    logic [7:0] ir;
    logic [7:0] wait_cnt;
    logic [7:0] mar_src;
    logic       idle;
    logic       start_read;
    logic       start_write;
    logic       txn_ok;
    logic       txn_timeout;

    // Strobes only count in IDLE; a write request overrides a RAM read request.
    assign idle        = (state == IDLE);
    assign start_write = idle & RAM_we;
    assign start_read  = idle & MBR_we & ~MBR_mux & ~RAM_we;
    assign txn_ok      = ~idle & mem_ack;
    assign txn_timeout = ~idle & ~mem_ack & (wait_cnt == TIMEOUT_LAST);
    assign mar_src     = MAR_mux ? {4'h0, ir[3:0]} : pc;

    assign pc_out  = pc;
    assign mbr_out = mbr;
    assign ir_out  = ir;

    // State register.
    always_ff @(posedge fu_clk or negedge fu_rst_n) begin
        if (!fu_rst_n) state <= IDLE;
        else           state <= next_state;
    end

    // Next state: open a transaction from IDLE, close it on ack or timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_write)     next_state = WRITE;
                else if (start_read) next_state = READ;
            end
            READ, WRITE: begin
                if (txn_ok || txn_timeout) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state: busy stalls the control unit.
    always_comb begin
        busy = 1'b0;
        if (state != IDLE) busy = 1'b1;
    end

    // Architectural registers; PC/MAR/IR move only in IDLE, MBR also takes read results.
    always_ff @(posedge fu_clk or negedge fu_rst_n) begin
        if (!fu_rst_n) begin
            pc  <= RESET_PC;
            mar <= 8'h00;
            mbr <= 8'h00;
            ir  <= 8'h00;
        end else begin
            if (idle && PC_inc) pc  <= pc + 8'd1;
            if (idle && MAR_we) mar <= mar_src;
            if (idle && IR_we)  ir  <= mbr;
            if (idle && MBR_we && MBR_mux)
                mbr <= rf_data;
            else if (state == READ && mem_ack)
                mbr <= mem_rdata;
            else if (state == READ && txn_timeout)
                mbr <= 8'hFF;
        end
    end

    // RAM handshake registers, wait counter and sticky timeout flag.
    always_ff @(posedge fu_clk or negedge fu_rst_n) begin
        if (!fu_rst_n) begin
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
            wait_cnt  <= 8'h00;
            mem_err   <= 1'b0;
        end else begin
            if (start_write || start_read) begin
                mem_req  <= 1'b1;
                mem_wr   <= start_write;
                mem_addr <= mar;
                wait_cnt <= 8'h00;
                if (start_write) mem_wdata <= mbr;
            end else if (txn_ok) begin
                mem_req <= 1'b0;
            end else if (!idle) begin
                wait_cnt <= wait_cnt + 8'd1;
                if (txn_timeout) begin
                    mem_req <= 1'b0;
                    mem_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed bench for fetch_mem_unit: fetch, wait states, store,
// timeout, PC wrap, write priority and reset during a read.
module tb_fetch_mem_unit;

    logic       fu_clk = 1'b0;
    logic       fu_rst_n = 1'b1;
    logic       PC_inc = 1'b0;
    logic       MAR_we = 1'b0;
    logic       MAR_mux = 1'b0;
    logic       MBR_we = 1'b0;
    logic       MBR_mux = 1'b0;
    logic       IR_we = 1'b0;
    logic       RAM_we = 1'b0;
    logic [7:0] rf_data = 8'h00;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
    logic       mem_req;
    logic       mem_wr;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] ir_out;
    logic [7:0] mbr_out;
    logic [7:0] pc_out;
    logic       busy;
    logic       mem_err;

    int checks = 0;
    int errors = 0;

    fetch_mem_unit #(.TIMEOUT(16), .RESET_PC(8'h00)) dut (
        .fu_clk    (fu_clk),
        .fu_rst_n  (fu_rst_n),
        .PC_inc    (PC_inc),
        .MAR_we    (MAR_we),
        .MAR_mux   (MAR_mux),
        .MBR_we    (MBR_we),
        .MBR_mux   (MBR_mux),
        .IR_we     (IR_we),
        .RAM_we    (RAM_we),
        .rf_data   (rf_data),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .ir_out    (ir_out),
        .mbr_out   (mbr_out),
        .pc_out    (pc_out),
        .busy      (busy),
        .mem_err   (mem_err)
    );

    always #5 fu_clk = ~fu_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pc_inc, input logic mar_we, input logic mar_mux,
                                 input logic mbr_we, input logic mbr_mux, input logic ir_we,
                                 input logic ram_we);
        PC_inc  = pc_inc;
        MAR_we  = mar_we;
        MAR_mux = mar_mux;
        MBR_we  = mbr_we;
        MBR_mux = mbr_mux;
        IR_we   = ir_we;
        RAM_we  = ram_we;
    endtask

    task automatic step();
        @(posedge fu_clk);
        #1;
    endtask

    initial begin
        // Reset
        #2 fu_rst_n = 1'b0;
        step();
        step();
        checkOutput("rst_pc", pc_out, 8'h00);
        checkOutput("rst_mbr", mbr_out, 8'h00);
        checkOutput("rst_ir", ir_out, 8'h00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_req", mem_req, 1'b0);
        checkOutput("rst_err", mem_err, 1'b0);
        checkOutput("rst_addr", mem_addr, 8'h00);
        checkOutput("rst_wdata", mem_wdata, 8'h00);
        fu_rst_n = 1'b1;
        step();

        // Fetch with zero-wait ack
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("fetch_req", mem_req, 1'b1);
        checkOutput("fetch_wr", mem_wr, 1'b0);
        checkOutput("fetch_addr", mem_addr, 8'h00);
        checkOutput("fetch_pc", pc_out, 8'h01);
        checkOutput("fetch_busy", busy, 1'b1);
        mem_ack = 1'b1;
        mem_rdata = 8'h3A;
        step();
        mem_ack = 1'b0;
        checkOutput("fetch_busy_end", busy, 1'b0);
        checkOutput("fetch_req_end", mem_req, 1'b0);
        checkOutput("fetch_mbr", mbr_out, 8'h3A);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("fetch_ir", ir_out, 8'h3A);

        // Read with three wait states; PC_inc during busy is ignored
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("wait_busy0", busy, 1'b1);
        checkOutput("wait_addr", mem_addr, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("wait_busy", busy, 1'b1);
        end
        mem_ack = 1'b1;
        mem_rdata = 8'hC5;
        step();
        mem_ack = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("wait_busy_end", busy, 1'b0);
        checkOutput("wait_mbr", mbr_out, 8'hC5);
        checkOutput("wait_pc_held", pc_out, 8'h01);

        // Store: IR=17 gives operand address 07, MBR from rf_data
        rf_data = 8'h17;
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
        step();
        checkOutput("store_mbr17", mbr_out, 8'h17);
        checkOutput("store_no_req", mem_req, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        step();
        checkOutput("store_ir", ir_out, 8'h17);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        step();
        rf_data = 8'h99;
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
        step();
        checkOutput("store_mbr99", mbr_out, 8'h99);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("store_req", mem_req, 1'b1);
        checkOutput("store_wr", mem_wr, 1'b1);
        checkOutput("store_addr", mem_addr, 8'h07);
        checkOutput("store_wdata", mem_wdata, 8'h99);
        step();
        checkOutput("store_hold_addr", mem_addr, 8'h07);
        checkOutput("store_hold_wdata", mem_wdata, 8'h99);
        mem_ack = 1'b1;
        mem_rdata = 8'h44;
        step();
        mem_ack = 1'b0;
        checkOutput("store_done", busy, 1'b0);
        checkOutput("store_mbr_kept", mbr_out, 8'h99);

        // Write with simultaneous rf_data load sends old MBR
        rf_data = 8'h55;
        applyStimulus(0, 0, 0, 1, 1, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_old_wdata", mem_wdata, 8'h99);
        checkOutput("wr_new_mbr", mbr_out, 8'h55);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;

        // Ack on the last allowed cycle counts as success
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step();
        checkOutput("edge_busy", busy, 1'b1);
        mem_ack = 1'b1;
        mem_rdata = 8'h66;
        step();
        mem_ack = 1'b0;
        checkOutput("edge_mbr", mbr_out, 8'h66);
        checkOutput("edge_err", mem_err, 1'b0);
        checkOutput("edge_busy_end", busy, 1'b0);

        // Timeout: no ack for 16 cycles in READ
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step();
        checkOutput("to_req_15", mem_req, 1'b1);
        checkOutput("to_err_15", mem_err, 1'b0);
        step();
        checkOutput("to_req", mem_req, 1'b0);
        checkOutput("to_busy", busy, 1'b0);
        checkOutput("to_mbr", mbr_out, 8'hFF);
        checkOutput("to_err", mem_err, 1'b1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        mem_ack = 1'b1;
        mem_rdata = 8'h5A;
        step();
        mem_ack = 1'b0;
        checkOutput("after_to_mbr", mbr_out, 8'h5A);
        checkOutput("after_to_err", mem_err, 1'b1);

        // PC wrap from FF to 00
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 254; i++) step();
        checkOutput("pc_ff", pc_out, 8'hFF);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pc_wrap", pc_out, 8'h00);

        // Write beats read when both are requested
        applyStimulus(1, 0, 0, 1, 0, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("prio_wr", mem_wr, 1'b1);
        checkOutput("prio_req", mem_req, 1'b1);
        checkOutput("prio_wdata", mem_wdata, 8'h5A);
        mem_ack = 1'b1;
        mem_rdata = 8'hEE;
        step();
        mem_ack = 1'b0;
        checkOutput("prio_mbr", mbr_out, 8'h5A);
        step();
        checkOutput("prio_no_read", mem_req, 1'b0);
        checkOutput("prio_pc", pc_out, 8'h01);

        // Reset in the middle of a read
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid_req", mem_req, 1'b1);
        fu_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_req", mem_req, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_pc", pc_out, 8'h00);
        checkOutput("mid_rst_mbr", mbr_out, 8'h00);
        checkOutput("mid_rst_err", mem_err, 1'b0);
        step();
        fu_rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 8'hAB;
        step();
        mem_ack = 1'b0;
        checkOutput("late_ack_mbr", mbr_out, 8'h00);
        checkOutput("late_ack_busy", busy, 1'b0);
        checkOutput("late_ack_req", mem_req, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_mem_unit.md
Name: fetch_mem_unit

Overview:
Memory-side datapath stage that sits directly upstream of the control unit. It holds PC, MAR, MBR and IR, and runs byte transactions to RAM over a req/ack handshake that may insert wait states. The control unit's strobes drive it. IR feeds the control unit's instruction input. busy tells the control unit to hold its current state until a RAM transaction completes.

Parameters:
TIMEOUT, 16, number of cycles in READ/WRITE without mem_ack before the transaction aborts with an error (legal range 2..255).
RESET_PC, 8'h00, PC value after reset.

Ports:
fu_clk  in  1  rising-edge clock.
fu_rst_n  in  1  asynchronous active-low reset.
PC_inc  in  1  increment PC.
MAR_we  in  1  load MAR.
MAR_mux  in  1  MAR source: 0 = PC, 1 = {4'h0, IR[3:0]} (operand address).
MBR_we  in  1  load MBR.
MBR_mux  in  1  MBR source: 0 = RAM read, 1 = rf_data.
IR_we  in  1  load IR from MBR.
RAM_we  in  1  write MBR to RAM at MAR.
rf_data  in  8  register-file read data, used for stores.
mem_rdata  in  8  RAM read data; valid when mem_ack=1.
mem_ack  in  1  RAM completion; sampled only while mem_req=1.
mem_req  out  1  transaction request (registered).
mem_wr  out  1  1 = write, 0 = read (registered).
mem_addr  out  8  transaction address (registered).
mem_wdata  out  8  write data (registered).
ir_out  out  8  IR contents, to control-unit instruction input.
mbr_out  out  8  MBR contents, to register-file write path.
pc_out  out  8  PC contents.
busy  out  1  high while state != IDLE.
mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, fu_rst_n=0):
  - PC=RESET_PC; MAR, MBR, IR = 0.
  - state=IDLE; wait counter = 0.
  - mem_req, mem_wr, mem_err = 0; mem_addr, mem_wdata = 0.
  - busy=0 immediately.
  - Reset during a transaction abandons it: mem_req drops asynchronously and no register updates.
- FSM states: IDLE, READ, WRITE.
- Strobes are accepted only in IDLE. All strobes, PC_inc included, are ignored while busy=1; the control unit must stall.
- Strobes in IDLE, applied on the same edge, are independent of each other:
  - PC_inc: PC <= PC+1 mod 256 (8'hFF wraps to 8'h00).
  - MAR_we: MAR <= selected source. With PC_inc also high, MAR takes the pre-increment PC.
  - IR_we: IR <= current MBR.
  - MBR_we with MBR_mux=1: MBR <= rf_data on the same edge; no RAM transaction.
- Starting a read: MBR_we=1, MBR_mux=0, RAM_we=0.
  - Next edge: state=READ, mem_req=1, mem_wr=0, mem_addr=MAR, counter=0.
  - MAR_we on that same edge does not affect this transaction's address.
- Starting a write: RAM_we=1.
  - Next edge: state=WRITE, mem_req=1, mem_wr=1, mem_addr=MAR, mem_wdata=MBR.
- Read and write requested together (RAM_we=1 with MBR_we=1, MBR_mux=0): write wins and the read is dropped.
- RAM_we=1 with MBR_we=1, MBR_mux=1: MBR loads rf_data, and the write sends the old MBR value.
- Each cycle in READ/WRITE with mem_ack=1:
  - READ: MBR <= mem_rdata.
  - mem_req <= 0; state <= IDLE.
- Each cycle in READ/WRITE with mem_ack=0:
  - counter increments.
  - If counter = TIMEOUT-1: mem_err <= 1, mem_req <= 0, state <= IDLE; in READ, MBR <= 8'hFF.
- mem_ack arriving on the same cycle as the timeout cycle counts as success and mem_err is not set.
- mem_ack while mem_req=0 is ignored.
- Latency for a zero-wait ack:
  - Strobe at edge N; mem_req and busy high after N.
  - mem_ack sampled at N+1; MBR valid and busy low after N+1.
  - Each wait cycle adds one cycle.
- mem_err is cleared only by reset. Later transactions proceed normally while it is set.
- mem_wr, mem_addr and mem_wdata hold their values while mem_req=1.

Test Plan:
- Fetch: after reset, assert MAR_we (MAR_mux=0), then MBR_we with PC_inc; RAM returns 8'h3A with zero wait -> mem_addr=00, PC=01, busy high exactly 1 cycle, MBR=3A; IR_we -> ir_out=3A.
- Wait states: mem_ack delayed 3 cycles on a read of 8'hC5 -> busy high 4 cycles; PC_inc asserted during busy is ignored; MBR=C5 afterwards.
- Store: IR=8'h17, MAR_mux=1 -> MAR=07; MBR_mux=1, MBR_we with rf_data=8'h99; then RAM_we -> mem_wr=1, mem_addr=07, mem_wdata=99 until ack.
- Timeout with TIMEOUT=16 and mem_ack never asserted -> mem_req drops after 16 cycles in READ, MBR=FF, mem_err=1 and stays 1; next read with ack completes normally.
- Wrap and priority: PC=FF with PC_inc -> PC=00; RAM_we and MBR_we (MBR_mux=0) together -> only a write transaction is issued.
- Reset mid-read: fu_rst_n low during READ -> mem_req and busy low immediately; PC=RESET_PC, MBR=00; a late mem_ack after release is ignored.
